// File: rtl/tick_pkg.sv
// Shared constants for the tick prescaler slice.
//   MODE_CONT / MODE_ONESHOT : encoding of the per-channel mode bit
//   TICK_DEFAULT_DIV         : divisor loaded at reset (period 256 cycles)
package tick_pkg;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam int TICK_DEFAULT_DIV = 255;

endpackage

// File: rtl/prescaler_chan.sv
// One prescaler channel: a programmable modulo counter that produces a
// registered one-cycle tick at the end of each period, a phase square wave,
// and supports one-shot operation and glitch-free divisor reload.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   en      in   count enable; count holds when low
//   mode    in   0 = continuous, 1 = one-shot
//   start   in   one-shot trigger (ignored in continuous mode)
//   clr     in   synchronous clear; highest priority
//   ld      in   divisor load strobe
//   div_in  in   divisor to load
//   tick    out  one-cycle pulse after each terminal count
//   busy    out  channel is counting
//   phase   out  toggles on every tick
module prescaler_chan
  import tick_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = TICK_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             busy,
  output logic             phase
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] div_pend;
  logic             pending;
  logic             armed;
  logic             active;
  logic             terminal;

  assign active = en & ((mode == MODE_CONT) | armed);
  // >= rather than == so that an idle load that lowered div_act below a held
  // count still ends the period on the next active cycle.
  assign terminal = active & (count >= div_act);
  // Gated by rst so busy reads 0 throughout reset even with en high in
  // continuous mode.
  assign busy = active & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      div_act <= WIDTH'(DEFAULT_DIV);
      pending <= 1'b0;
      armed   <= 1'b0;
      tick    <= 1'b0;
      phase   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr) begin
        count   <= '0;
        armed   <= 1'b0;
        pending <= 1'b0;
        phase   <= 1'b0;
      end else begin
        if (terminal) begin
          count <= '0;
          tick  <= 1'b1;
          phase <= ~phase;
          if (mode == MODE_ONESHOT) armed <= 1'b0;
          // A load coinciding with the terminal supersedes any pending value
          // and governs the very next period.
          if (ld) begin
            div_act <= div_in;
            pending <= 1'b0;
          end else if (pending) begin
            div_act <= div_pend;
            pending <= 1'b0;
          end
        end else begin
          if (active) count <= count + WIDTH'(1);
          if (ld) begin
            if (active) begin
              pending <= 1'b1;
            end else begin
              div_act <= div_in;
              pending <= 1'b0;
            end
          end
        end
        // start overrides the increment above: a re-trigger restarts from 0,
        // and on a terminal cycle the tick above still goes out.
        if (mode == MODE_ONESHOT) begin
          if (start) begin
            armed <= 1'b1;
            count <= '0;
          end
        end else begin
          armed <= 1'b0;
        end
      end
    end
  end

  // Pending divisor value: only meaningful while pending is set, so it needs
  // no reset.
  always_ff @(posedge clk) begin
    if (!clr && !terminal && ld && active) div_pend <= div_in;
  end

endmodule

// File: rtl/tick_prescaler.sv
// Multi-channel runtime-programmable clock-enable generator. Each channel is
// an independent prescaler_chan; all outputs are enables in the clk domain.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   en      in   [NCH]        per-channel count enable
//   mode    in   [NCH]        0 = continuous, 1 = one-shot
//   start   in   [NCH]        one-shot trigger
//   clr     in   [NCH]        synchronous channel clear
//   ld      in   [NCH]        divisor load strobe
//   div_in  in   [NCH*WIDTH]  packed divisors, channel k at [k*WIDTH +: WIDTH]
//   tick    out  [NCH]        one-cycle end-of-period pulse
//   busy    out  [NCH]        channel counting
//   phase   out  [NCH]        square wave, period 2*(div+1)
module tick_prescaler
  import tick_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NCH         = 2,
  parameter int DEFAULT_DIV = TICK_DEFAULT_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       ld,
  input  logic [NCH*WIDTH-1:0] div_in,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       phase
);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    prescaler_chan #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en    (en[k]),
      .mode  (mode[k]),
      .start (start[k]),
      .clr   (clr[k]),
      .ld    (ld[k]),
      .div_in(div_in[k*WIDTH +: WIDTH]),
      .tick  (tick[k]),
      .busy  (busy[k]),
      .phase (phase[k])
    );
  end

endmodule

// File: tb/tb_tick_prescaler.sv
module tb_tick_prescaler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en, mode, start, clr, ld;
  logic [15:0] div_in;
  logic [1:0]  tick, busy, phase;

  int compared   = 0;
  int mismatched = 0;
  int nt, ft, nb;

  tick_prescaler #(.WIDTH(8), .NCH(2), .DEFAULT_DIV(255)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .clr(clr),
    .ld(ld), .div_in(div_in), .tick(tick), .busy(busy), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run n cycles, sampling 1 time unit after each rising edge; report the
  // number of ticks, index of the first tick (0 = none) and busy samples.
  task automatic run(input int n, input int ch, output int ticks,
                     output int first, output int busyc);
    ticks = 0; first = 0; busyc = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (tick[ch]) begin
        ticks++;
        if (first == 0) first = i;
      end
      if (busy[ch]) busyc++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 2'b11; mode = 2'b00; start = 2'b00; clr = 2'b00;
    ld = 2'b00; div_in = 16'h0000;

    // Reset state, en high in continuous mode must still show busy 0
    run(2, 0, nt, ft, nb);
    chk("rst_tick", int'(tick), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_busy", int'(busy), 0);

    // Free run on channel 0 with default divisor 255
    en = 2'b01;
    rst = 1'b0;
    run(255, 0, nt, ft, nb);
    chk("free_no_early_tick", nt, 0);
    chk("free_busy", nb, 255);
    run(1, 0, nt, ft, nb);
    chk("free_tick_256", nt, 1);
    chk("free_phase_1", int'(phase[0]), 1);
    run(255, 0, nt, ft, nb);
    chk("free_gap_512", nt, 0);
    run(1, 0, nt, ft, nb);
    chk("free_tick_512", nt, 1);
    chk("free_phase_0", int'(phase[0]), 0);
    run(256, 0, nt, ft, nb);
    chk("free_tick_768_at", ft, 256);
    chk("free_tick_768_n", nt, 1);

    // Reload mid-run: load 3 at count 100, period still ends at 256
    run(100, 0, nt, ft, nb);
    div_in[7:0] = 8'd3; ld = 2'b01;
    run(1, 0, nt, ft, nb);
    ld = 2'b00; div_in[7:0] = 8'd0;
    run(155, 0, nt, ft, nb);
    chk("reload_old_period_n", nt, 1);
    chk("reload_old_period_at", ft, 155);
    run(12, 0, nt, ft, nb);
    chk("reload_new_n", nt, 3);
    chk("reload_new_first", ft, 4);
    chk("reload_phase", int'(phase[0]), 1);

    // Gating on channel 1 with div 15 (idle load applies immediately)
    en = 2'b00;
    div_in[15:8] = 8'd15; ld = 2'b10;
    run(1, 1, nt, ft, nb);
    ld = 2'b00;
    en = 2'b10;
    run(5, 1, nt, ft, nb);
    en = 2'b00;
    run(50, 1, nt, ft, nb);
    chk("gate_hold_no_tick", nt, 0);
    chk("gate_busy_low", nb, 0);
    en = 2'b10;
    run(11, 1, nt, ft, nb);
    chk("gate_delayed_n", nt, 1);
    chk("gate_delayed_at", ft, 11);

    // Clear at count 8: no tick, phase back to 0, full period afterwards
    run(8, 1, nt, ft, nb);
    clr = 2'b10;
    run(1, 1, nt, ft, nb);
    clr = 2'b00;
    chk("clr_no_tick", nt, 0);
    chk("clr_phase", int'(phase[1]), 0);
    run(16, 1, nt, ft, nb);
    chk("clr_restart_n", nt, 1);
    chk("clr_restart_at", ft, 16);

    // div = 0: tick every active cycle
    en = 2'b00;
    div_in[15:8] = 8'd0; ld = 2'b10;
    run(1, 1, nt, ft, nb);
    ld = 2'b00;
    en = 2'b10;
    run(5, 1, nt, ft, nb);
    chk("div0_ticks", nt, 5);
    chk("div0_phase", int'(phase[1]), 0);

    // One-shot with div 9
    en = 2'b00; mode = 2'b10;
    div_in[15:8] = 8'd9; ld = 2'b10;
    run(1, 1, nt, ft, nb);
    ld = 2'b00;
    en = 2'b10;
    run(1, 1, nt, ft, nb);
    chk("os_idle_busy", int'(busy[1]), 0);
    start = 2'b10;
    run(1, 1, nt, ft, nb);
    start = 2'b00;
    chk("os_armed_busy", int'(busy[1]), 1);
    run(10, 1, nt, ft, nb);
    chk("os_tick_n", nt, 1);
    chk("os_tick_at", ft, 10);
    chk("os_busy_cycles", nb, 9);
    run(100, 1, nt, ft, nb);
    chk("os_quiet_ticks", nt, 0);
    chk("os_quiet_busy", nb, 0);

    // start coincident with terminal: tick plus re-arm
    start = 2'b10;
    run(1, 1, nt, ft, nb);
    start = 2'b00;
    run(9, 1, nt, ft, nb);
    start = 2'b10;
    run(1, 1, nt, ft, nb);
    start = 2'b00;
    chk("os_term_start_tick", nt, 1);
    chk("os_term_start_busy", int'(busy[1]), 1);
    run(10, 1, nt, ft, nb);
    chk("os_rearm_at", ft, 10);
    chk("os_rearm_busy_end", int'(busy[1]), 0);

    // ld on terminal cycle, continuous: new divisor for the next period
    mode = 2'b00;
    run(9, 1, nt, ft, nb);
    div_in[15:8] = 8'd2; ld = 2'b10;
    run(1, 1, nt, ft, nb);
    ld = 2'b00;
    chk("ld_term_tick", nt, 1);
    run(6, 1, nt, ft, nb);
    chk("ld_term_new_n", nt, 2);
    chk("ld_term_new_first", ft, 3);
    run(3, 1, nt, ft, nb);
    chk("pre_rst_tick", int'(tick[1]), 1);
    chk("pre_rst_phase", int'(phase[1]), 1);
    chk("pre_rst_busy", int'(busy[1]), 1);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_tick", int'(tick), 0);
    chk("arst_phase", int'(phase), 0);
    chk("arst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(256, 1, nt, ft, nb);
    chk("arst_default_div_n", nt, 1);
    chk("arst_default_div_at", ft, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tick_prescaler.md
Name: tick_prescaler

Overview:
Multi-channel, runtime-programmable clock-enable generator. It is the parametrised successor to the fixed divide-by-256 slow-enable and drives game-speed, debounce and LED-scan enables in the Tug-of-War datapath. Each channel has its own divisor, its own run/one-shot mode, glitch-free divisor reload, and a square-wave phase output. All outputs are single-clock-domain enables; no derived clocks.

Parameters:
WIDTH, 8, counter and divisor width per channel
NCH, 2, number of independent channels
DEFAULT_DIV, 255, divisor loaded at reset (period = DEFAULT_DIV+1 = 256 cycles)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  NCH  per-channel count enable; count holds when low
mode  in  NCH  0 = continuous, 1 = one-shot
start  in  NCH  one-shot trigger pulse; ignored in continuous mode
clr  in  NCH  synchronous clear of the channel counter
ld  in  NCH  divisor load strobe
div_in  in  NCH*WIDTH  packed divisors; channel k uses bits [k*WIDTH +: WIDTH]
tick  out  NCH  one-cycle enable pulse at end of each period
busy  out  NCH  channel is counting (continuous: en high; one-shot: armed)
phase  out  NCH  toggles on every tick; square wave of period 2*(div+1)

Behaviour:
- Reset (async, rst=1) sets count=0, div_act=DEFAULT_DIV, pending flag=0, armed=0, tick=0, phase=0, busy=0. Reset asserted mid-period aborts the period immediately, with no tick.
- Active cycle: en[k]=1 and (mode=0, or mode=1 with armed=1).
- On an active cycle with count<div_act: count<=count+1.
- On an active cycle with count==div_act (terminal): count<=0, tick<=1 on the next cycle, phase toggles.
- Ticks are registered, so the first tick lands WIDTH-independent div_act+1 edges after counting starts. Example: div=255 with en high from reset release gives tick high after edge 256, then every 256 cycles.
- tick is high for exactly one cycle per terminal. div_act=0 gives tick every active cycle.
- Inactive cycle: count, phase and pending state hold; tick=0.
- One-shot mode:
  - start sets armed and count<=0.
  - Terminal produces one tick and clears armed.
  - start while armed restarts from 0, with no tick.
  - start coincident with terminal: the tick is issued and the channel re-arms with count=0.
- busy = en & (mode==0 | armed). It is combinational from registered state and is 0 in reset.
- Divisor load, when channel is not busy: div_act<=div_in immediately.
- Divisor load, when channel is busy: value goes to div_pend and pending is set.
  - At the next terminal, div_act<=div_pend and pending clears.
  - The current period always completes with the old divisor.
- Multiple ld before terminal: last value wins.
- ld in the same cycle as terminal: div_in becomes div_act for the very next period.
- clr has priority over start, ld and counting:
  - Effects: count<=0, armed<=0, pending discarded, phase<=0, no tick that cycle.
  - div_act is preserved.
- Mode change mid-run takes effect next cycle. Switching 0->1 leaves the channel idle (armed=0) until start.
- Arithmetic: WIDTH-bit unsigned. Count never exceeds div_act.
- Lowering div_act below the current count via an idle ld with a held count: the next active cycle treats count>=div_act as terminal.
- Channels are fully independent; simultaneous events on different channels do not interact.

Decomposition:
- Shared package tick_pkg holds MODE_CONT=1'b0, MODE_ONESHOT=1'b1, and the default-divisor constant.
- One sub-module, prescaler_chan, implements a single channel: count, div_act, div_pend, pending, armed, phase and tick registers.
- The top-level instantiates prescaler_chan NCH times in a generate loop and slices div_in.

Test Plan:
- Free run: rst pulse, en[0]=1, mode=0, no ld -> tick[0] after edges 256, 512, 768; phase[0] toggles at each tick; busy[0]=1.
- Reload mid-run: div=255 running, ld div_in=3 at count 100 -> next tick still at edge 256, then ticks every 4 cycles; div_act=3 only after that tick.
- One-shot: mode=1, ld 9 while idle, start pulse -> busy 1 for 10 cycles, exactly one tick, then busy 0 and no further ticks for 100 cycles.
- Gating/clear: continuous div=15, drop en for 50 cycles at count 5 -> tick delayed by exactly 50 cycles. clr at count 8 -> no tick, count restarts, next tick 16 active cycles later.
- Corner: div=0 -> tick every active cycle. start on terminal cycle -> tick plus re-arm. ld on terminal cycle -> new divisor applies to the following period.
- Reset mid-operation: assert rst asynchronously at count 200 -> tick, phase and busy go 0 immediately, and div_act returns to 255.
